// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states, RX FIFO entry layout
// and a 3-input majority helper used by the oversampling vote.
package uart_defs;

   localparam int RX_DATA_MAX = 9;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } Parity_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } RxOsState_t;

   typedef struct packed {
      logic                   brk;
      logic                   frame_err;
      logic                   parity_err;
      logic [RX_DATA_MAX-1:0] data;
   } RxEntry_t;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with valid/ready style push/pop, flush and occupancy count.
// The head word reads as zero while empty so downstream outputs stay clean.
module uart_sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      level_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q;
   logic [AW-1:0]    rptr_q;
   logic [AW:0]      level_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == (AW+1)'(DEPTH));
   assign level_o = level_q;
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else if (flush_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         level_q <= level_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

   // NOTE: storage has no reset; validity is tracked by the pointers and level alone.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchroniser, sample-tick prescaler, majority-vote
// framing FSM with runtime data/parity/stop configuration, RX FIFO and RTS flow control.
module uart_rx_os
   import uart_defs::*;
#(
   parameter int DATA_MAX    = RX_DATA_MAX,
   parameter int OVERSAMPLE  = 16,
   parameter int FIFO_DEPTH  = 8,
   parameter int RTS_MARGIN  = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rx_enable_i,
   input  logic [15:0]                   baud_div_i,
   input  logic [3:0]                    data_bits_i,
   input  Parity_t                       parity_i,
   input  logic                          stop2_i,
   input  logic                          flush_i,
   input  logic                          clr_overrun_i,
   input  logic                          rx_i,
   output logic                          rts_n_o,
   output logic [DATA_MAX-1:0]           rx_data_o,
   output logic                          rx_parity_err_o,
   output logic                          rx_frame_err_o,
   output logic                          rx_break_o,
   output logic                          rx_valid_o,
   input  logic                          rx_ready_i,
   output logic                          overrun_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic                          busy_o,
   output logic                          wakeup_o
);

   localparam int SCW = $clog2(OVERSAMPLE);
   localparam int LVW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [SCW-1:0] SC_A   = SCW'(OVERSAMPLE/2 - 1);
   localparam logic [SCW-1:0] SC_B   = SCW'(OVERSAMPLE/2);
   localparam logic [SCW-1:0] SC_V   = SCW'(OVERSAMPLE/2 + 1);
   localparam logic [SCW-1:0] SC_END = SCW'(OVERSAMPLE - 1);

   typedef struct packed {
      logic                brk;
      logic                frame_err;
      logic                parity_err;
      logic [DATA_MAX-1:0] data;
   } entry_t;

   function automatic logic [3:0] clamp_bits(input logic [3:0] b);
      if (b < 4'd5)            return 4'd5;
      if (b > 4'(DATA_MAX))    return 4'(DATA_MAX);
      return b;
   endfunction

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxs;
   logic [15:0]            presc_q;
   logic                   tick;

   RxOsState_t             state_q;
   logic [SCW-1:0]         scnt_q;
   logic [3:0]             bcnt_q;
   logic [DATA_MAX-1:0]    shreg_q;
   logic                   acc_q;
   logic                   perr_q;
   logic                   ferr_q;
   logic                   pbit_q;
   logic                   sa_q;
   logic                   sb_q;
   logic                   stop_idx_q;
   logic [3:0]             bits_q;
   Parity_t                par_q;
   logic                   stop2_q;
   logic                   wakeup_q;
   logic                   rts_n_q;
   logic                   overrun_q;

   logic                   vote_d;
   logic                   push_d;
   logic                   frame_err_d;
   logic                   brk_d;
   entry_t                 entry_d;
   entry_t                 head;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   pop;
   logic                   overrun_set;
   logic [LVW-1:0]         level;
   logic [LVW-1:0]         free_d;

   assign rxs  = sync_q[SYNC_STAGES-1];
   assign tick = (presc_q >= baud_div_i);

   // Line idles high, so the synchroniser resets to 1 to avoid a phantom start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '1;
         presc_q <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_i};
         presc_q <= tick ? 16'd0 : presc_q + 16'd1;
      end
   end

   // NOTE: every signal assigned here gets a default first so no latch is inferred.
   always_comb begin
      vote_d      = majority3(sa_q, sb_q, rxs);
      push_d      = tick && (state_q == STOP) && (scnt_q == SC_V) && (stop_idx_q == stop2_q);
      frame_err_d = ferr_q | ~vote_d;
      brk_d       = frame_err_d && (shreg_q == '0) && ((par_q == PAR_NONE) || !pbit_q);
      entry_d     = '{brk: brk_d, frame_err: frame_err_d, parity_err: perr_q, data: shreg_q};
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         scnt_q     <= '0;
         bcnt_q     <= '0;
         shreg_q    <= '0;
         acc_q      <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         pbit_q     <= 1'b0;
         sa_q       <= 1'b1;
         sb_q       <= 1'b1;
         stop_idx_q <= 1'b0;
         bits_q     <= 4'd8;
         par_q      <= PAR_NONE;
         stop2_q    <= 1'b0;
         wakeup_q   <= 1'b0;
      end else begin
         wakeup_q <= 1'b0;
         if (tick) begin
            if (scnt_q == SC_A) sa_q <= rxs;
            if (scnt_q == SC_B) sb_q <= rxs;
            if (state_q != IDLE) scnt_q <= (scnt_q == SC_END) ? '0 : scnt_q + 1'b1;

            case (state_q)
               IDLE: begin
                  if (!rxs && rx_enable_i) begin
                     state_q <= START;
                     scnt_q  <= '0;
                     bits_q  <= clamp_bits(data_bits_i);
                     par_q   <= parity_i;
                     stop2_q <= stop2_i;
                  end
               end
               START: begin
                  if (scnt_q == SC_V) begin
                     if (vote_d) state_q  <= IDLE;
                     else        wakeup_q <= 1'b1;
                  end
                  if (scnt_q == SC_END) begin
                     state_q <= DATA;
                     bcnt_q  <= '0;
                     acc_q   <= 1'b0;
                     shreg_q <= '0;
                     perr_q  <= 1'b0;
                     ferr_q  <= 1'b0;
                     pbit_q  <= 1'b0;
                  end
               end
               DATA: begin
                  if (scnt_q == SC_V) begin
                     shreg_q[bcnt_q] <= vote_d;
                     acc_q           <= acc_q ^ vote_d;
                  end
                  if (scnt_q == SC_END) begin
                     if (bcnt_q == bits_q - 4'd1) begin
                        state_q    <= (par_q != PAR_NONE) ? PARITY : STOP;
                        stop_idx_q <= 1'b0;
                     end else begin
                        bcnt_q <= bcnt_q + 4'd1;
                     end
                  end
               end
               PARITY: begin
                  if (scnt_q == SC_V) begin
                     pbit_q <= vote_d;
                     perr_q <= (par_q == PAR_ODD) ? ~(acc_q ^ vote_d) : (acc_q ^ vote_d);
                  end
                  if (scnt_q == SC_END) begin
                     state_q    <= STOP;
                     stop_idx_q <= 1'b0;
                  end
               end
               STOP: begin
                  // Leave on the final vote rather than at bit end so a following start edge is not missed.
                  if (scnt_q == SC_V) begin
                     if (!vote_d) ferr_q <= 1'b1;
                     if (stop_idx_q == stop2_q) state_q <= IDLE;
                  end
                  if (scnt_q == SC_END) stop_idx_q <= 1'b1;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign pop         = rx_ready_i & ~fifo_empty;
   assign overrun_set = push_d & fifo_full & ~pop;
   assign free_d      = LVW'(FIFO_DEPTH) - level;

   uart_sync_fifo #(
      .WIDTH (DATA_MAX + 3),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_d),
      .wdata_i (entry_d),
      .pop_i   (pop),
      .flush_i (flush_i),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (level)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rts_n_q   <= 1'b1;
         overrun_q <= 1'b0;
      end else begin
         rts_n_q <= ~(rx_enable_i & (free_d > LVW'(RTS_MARGIN)));
         if (overrun_set)        overrun_q <= 1'b1;
         else if (clr_overrun_i) overrun_q <= 1'b0;
      end
   end

   assign rts_n_o         = rts_n_q;
   assign overrun_o       = overrun_q;
   assign wakeup_o        = wakeup_q;
   assign busy_o          = (state_q != IDLE);
   assign rx_valid_o      = ~fifo_empty;
   assign fifo_level_o    = level;
   assign rx_data_o       = head.data;
   assign rx_parity_err_o = head.parity_err;
   assign rx_frame_err_o  = head.frame_err;
   assign rx_break_o      = head.brk;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: framing formats, error/break flags, false start,
// FIFO overrun and flow control, full-with-pop, flush and mid-frame reset.
module tb_uart_rx_os;
   import uart_defs::*;

   localparam int OS = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_enable_i;
   logic [15:0] baud_div_i;
   logic [3:0]  data_bits_i;
   Parity_t     parity_i;
   logic        stop2_i;
   logic        flush_i;
   logic        clr_overrun_i;
   logic        rx_i;
   logic        rts_n_o;
   logic [8:0]  rx_data_o;
   logic        rx_parity_err_o;
   logic        rx_frame_err_o;
   logic        rx_break_o;
   logic        rx_valid_o;
   logic        rx_ready_i;
   logic        overrun_o;
   logic [3:0]  fifo_level_o;
   logic        busy_o;
   logic        wakeup_o;

   int checks = 0;
   int errors = 0;
   int wake_cnt = 0;

   always #5 clk = ~clk;

   always @(negedge clk) if (wakeup_o) wake_cnt++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   uart_rx_os dut (
      .clk             (clk),
      .rst             (rst),
      .rx_enable_i     (rx_enable_i),
      .baud_div_i      (baud_div_i),
      .data_bits_i     (data_bits_i),
      .parity_i        (parity_i),
      .stop2_i         (stop2_i),
      .flush_i         (flush_i),
      .clr_overrun_i   (clr_overrun_i),
      .rx_i            (rx_i),
      .rts_n_o         (rts_n_o),
      .rx_data_o       (rx_data_o),
      .rx_parity_err_o (rx_parity_err_o),
      .rx_frame_err_o  (rx_frame_err_o),
      .rx_break_o      (rx_break_o),
      .rx_valid_o      (rx_valid_o),
      .rx_ready_i      (rx_ready_i),
      .overrun_o       (overrun_o),
      .fifo_level_o    (fifo_level_o),
      .busy_o          (busy_o),
      .wakeup_o        (wakeup_o)
   );

   task automatic bit_wait();
      repeat (OS) @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [8:0] d, input int nbits, input Parity_t par,
                             input bit bad_par, input bit s1, input bit s2, input bit two);
      logic p;
      p = 1'b0;
      rx_i = 1'b0;
      bit_wait();
      for (int i = 0; i < nbits; i++) begin
         rx_i = d[i];
         p    = p ^ d[i];
         bit_wait();
      end
      if (par != PAR_NONE) begin
         rx_i = (par == PAR_ODD) ? ~p : p;
         if (bad_par) rx_i = ~rx_i;
         bit_wait();
      end
      rx_i = s1;
      bit_wait();
      if (two) begin
         rx_i = s2;
         bit_wait();
      end
      rx_i = 1'b1;
   endtask

   task automatic do_pop();
      rx_ready_i = 1'b1;
      @(negedge clk);
      rx_ready_i = 1'b0;
   endtask

   task automatic config_fmt(input logic [3:0] bits, input Parity_t par, input logic two);
      data_bits_i = bits;
      parity_i    = par;
      stop2_i     = two;
   endtask

   // Returns with the bench sitting on the negedge right after the wakeup pulse edge.
   task automatic wait_wakeup(input string name, output bit found);
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (wakeup_o) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL %s: no wakeup pulse within 200 cycles", name);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle(3);
      checks++;
      if ({rts_n_o, rx_valid_o, overrun_o, busy_o, wakeup_o} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctrl: got rts/valid/ovr/busy/wake=%b want 10000",
                  {rts_n_o, rx_valid_o, overrun_o, busy_o, wakeup_o});
      end
      checks++;
      if ({rx_data_o, rx_parity_err_o, rx_frame_err_o, rx_break_o, fifo_level_o} !== '0) begin
         errors++;
         $display("FAIL reset_data: got data=%h pe=%b fe=%b brk=%b lvl=%0d want all 0",
                  rx_data_o, rx_parity_err_o, rx_frame_err_o, rx_break_o, fifo_level_o);
      end
      rst = 1'b0;
      idle(2);
      checks++;
      if (rts_n_o !== 1'b0) begin
         errors++;
         $display("FAIL rts_after_reset: got %b want 0", rts_n_o);
      end
   endtask

   task automatic test_8e1();
      int w0;
      bit found;
      logic v_before;
      logic v_after;
      config_fmt(4'd8, PAR_EVEN, 1'b0);
      w0 = wake_cnt;
      v_before = 1'b1;
      v_after  = 1'b0;
      fork
         send_frame(9'h0A5, 8, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1'b0);
         begin
            wait_wakeup("8e1_wakeup", found);
            if (found) begin
               // Stop vote is 10 bit times after the start vote (8 data + parity + stop).
               repeat (10*OS - 1) @(negedge clk);
               v_before = rx_valid_o;
               @(negedge clk);
               v_after = rx_valid_o;
            end
         end
      join
      idle(4);
      checks++;
      if (v_before !== 1'b0 || v_after !== 1'b1) begin
         errors++;
         $display("FAIL 8e1_latency: valid before/after stop vote=%b%b want 01", v_before, v_after);
      end
      checks++;
      if (rx_data_o !== 9'h0A5) begin
         errors++;
         $display("FAIL 8e1_data: got %h want 0a5", rx_data_o);
      end
      checks++;
      if ({rx_parity_err_o, rx_frame_err_o, rx_break_o} !== 3'b000) begin
         errors++;
         $display("FAIL 8e1_flags: got pe/fe/brk=%b want 000",
                  {rx_parity_err_o, rx_frame_err_o, rx_break_o});
      end
      checks++;
      if (wake_cnt - w0 != 1) begin
         errors++;
         $display("FAIL 8e1_wakeups: got %0d want 1", wake_cnt - w0);
      end
      do_pop();
      checks++;
      if (rx_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL 8e1_pop: got valid=%b busy=%b want 0 0", rx_valid_o, busy_o);
      end
   endtask

   task automatic test_7o2();
      config_fmt(4'd7, PAR_ODD, 1'b1);
      send_frame(9'h03C, 7, PAR_ODD, 1'b1, 1'b1, 1'b0, 1'b1);
      idle(40);
      checks++;
      if (rx_valid_o !== 1'b1 || rx_data_o !== 9'h03C) begin
         errors++;
         $display("FAIL 7o2_data: got valid=%b data=%h want 1 03c", rx_valid_o, rx_data_o);
      end
      checks++;
      if ({rx_parity_err_o, rx_frame_err_o, rx_break_o} !== 3'b110) begin
         errors++;
         $display("FAIL 7o2_flags: got pe/fe/brk=%b want 110",
                  {rx_parity_err_o, rx_frame_err_o, rx_break_o});
      end
      do_pop();
   endtask

   task automatic test_9n1_break();
      config_fmt(4'd9, PAR_NONE, 1'b0);
      send_frame(9'h1FF, 9, PAR_NONE, 1'b0, 1'b1, 1'b1, 1'b0);
      send_frame(9'h000, 9, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(40);
      checks++;
      if (fifo_level_o !== 4'd2) begin
         errors++;
         $display("FAIL 9n1_level: got %0d want 2", fifo_level_o);
      end
      checks++;
      if (rx_data_o !== 9'h1FF || {rx_parity_err_o, rx_frame_err_o, rx_break_o} !== 3'b000) begin
         errors++;
         $display("FAIL 9n1_first: got data=%h pe/fe/brk=%b want 1ff 000",
                  rx_data_o, {rx_parity_err_o, rx_frame_err_o, rx_break_o});
      end
      do_pop();
      checks++;
      if (rx_data_o !== 9'h000 || {rx_parity_err_o, rx_frame_err_o, rx_break_o} !== 3'b011) begin
         errors++;
         $display("FAIL 9n1_break: got data=%h pe/fe/brk=%b want 000 011",
                  rx_data_o, {rx_parity_err_o, rx_frame_err_o, rx_break_o});
      end
      do_pop();
   endtask

   task automatic test_false_start();
      int w0;
      logic busy_mid;
      w0 = wake_cnt;
      rx_i = 1'b0;
      idle(5);
      rx_i = 1'b1;
      busy_mid = busy_o;
      idle(20);
      checks++;
      if (busy_mid !== 1'b1 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL glitch_busy: got during/after=%b%b want 10", busy_mid, busy_o);
      end
      checks++;
      if (wake_cnt != w0 || rx_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL glitch_nopush: got wakeups=%0d valid=%b want 0 0", wake_cnt - w0, rx_valid_o);
      end
   endtask

   task automatic test_overrun_rts();
      config_fmt(4'd8, PAR_NONE, 1'b0);
      for (int i = 0; i < 9; i++) begin
         send_frame(9'(i), 8, PAR_NONE, 1'b0, 1'b1, 1'b1, 1'b0);
         if (i == 4) begin
            checks++;
            if (fifo_level_o !== 4'd5 || rts_n_o !== 1'b0) begin
               errors++;
               $display("FAIL rts_level5: got lvl=%0d rts_n=%b want 5 0", fifo_level_o, rts_n_o);
            end
         end
         if (i == 5) begin
            checks++;
            if (fifo_level_o !== 4'd6 || rts_n_o !== 1'b1) begin
               errors++;
               $display("FAIL rts_level6: got lvl=%0d rts_n=%b want 6 1", fifo_level_o, rts_n_o);
            end
         end
         if (i == 7) begin
            checks++;
            if (fifo_level_o !== 4'd8 || overrun_o !== 1'b0) begin
               errors++;
               $display("FAIL full_no_ovr: got lvl=%0d ovr=%b want 8 0", fifo_level_o, overrun_o);
            end
         end
      end
      idle(4);
      checks++;
      if (fifo_level_o !== 4'd8 || overrun_o !== 1'b1 || rx_data_o !== 9'h000) begin
         errors++;
         $display("FAIL overrun_drop: got lvl=%0d ovr=%b head=%h want 8 1 000",
                  fifo_level_o, overrun_o, rx_data_o);
      end
      clr_overrun_i = 1'b1;
      @(negedge clk);
      clr_overrun_i = 1'b0;
      checks++;
      if (overrun_o !== 1'b0) begin
         errors++;
         $display("FAIL clr_overrun: got %b want 0", overrun_o);
      end
   endtask

   task automatic test_full_pop_flush();
      bit found;
      // 8N1: stop vote falls 9 bit times after the start vote.
      fork
         send_frame(9'h055, 8, PAR_NONE, 1'b0, 1'b1, 1'b1, 1'b0);
         begin
            wait_wakeup("fullpop_wakeup", found);
            if (found) begin
               repeat (9*OS - 1) @(negedge clk);
               rx_ready_i = 1'b1;
               @(negedge clk);
               rx_ready_i = 1'b0;
            end
         end
      join
      idle(4);
      checks++;
      if (fifo_level_o !== 4'd8 || overrun_o !== 1'b0 || rx_data_o !== 9'h001) begin
         errors++;
         $display("FAIL full_pop: got lvl=%0d ovr=%b head=%h want 8 0 001",
                  fifo_level_o, overrun_o, rx_data_o);
      end
      fork
         send_frame(9'h066, 8, PAR_NONE, 1'b0, 1'b1, 1'b1, 1'b0);
         begin
            wait_wakeup("flush_wakeup", found);
            if (found) begin
               repeat (9*OS - 1) @(negedge clk);
               flush_i    = 1'b1;
               rx_ready_i = 1'b1;
               @(negedge clk);
               flush_i    = 1'b0;
               rx_ready_i = 1'b0;
            end
         end
      join
      idle(4);
      checks++;
      if (fifo_level_o !== 4'd0 || rx_valid_o !== 1'b0 || overrun_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_push: got lvl=%0d valid=%b ovr=%b want 0 0 0",
                  fifo_level_o, rx_valid_o, overrun_o);
      end
   endtask

   task automatic test_reset_midframe();
      logic busy_pre;
      send_frame(9'h011, 8, PAR_NONE, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(4);
      busy_pre = 1'b0;
      fork
         send_frame(9'h0F0, 8, PAR_NONE, 1'b0, 1'b1, 1'b1, 1'b0);
         begin
            idle(60);
            busy_pre = busy_o;
            rst = 1'b1;
            @(negedge clk);
            checks++;
            if ({rts_n_o, rx_valid_o, overrun_o, busy_o, wakeup_o} !== 5'b10000 ||
                fifo_level_o !== 4'd0 || rx_data_o !== 9'h000 ||
                {rx_parity_err_o, rx_frame_err_o, rx_break_o} !== 3'b000) begin
               errors++;
               $display("FAIL reset_midframe: got rts/valid/ovr/busy/wake=%b lvl=%0d data=%h want 10000 0 000",
                        {rts_n_o, rx_valid_o, overrun_o, busy_o, wakeup_o}, fifo_level_o, rx_data_o);
            end
         end
      join
      checks++;
      if (busy_pre !== 1'b1) begin
         errors++;
         $display("FAIL busy_midframe: got %b want 1", busy_pre);
      end
      rst = 1'b0;
      idle(10);
   endtask

   initial begin
      rst           = 1'b1;
      rx_enable_i   = 1'b1;
      baud_div_i    = 16'd0;
      data_bits_i   = 4'd8;
      parity_i      = PAR_NONE;
      stop2_i       = 1'b0;
      flush_i       = 1'b0;
      clr_overrun_i = 1'b0;
      rx_i          = 1'b1;
      rx_ready_i    = 1'b0;
      @(negedge clk);

      test_reset();
      test_8e1();
      idle(20);
      test_7o2();
      idle(20);
      test_9n1_break();
      idle(20);
      test_false_start();
      idle(20);
      test_overrun_rts();
      test_full_pop_flush();
      idle(20);
      test_reset_midframe();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
